// File: rtl/core_mem_pkg.sv
// Memory-side widths and encodings shared by the core, the MMU and the RAM port arbiter.
package core_mem_pkg;

  localparam int unsigned WORD_ADDR_W = 14;
  localparam int unsigned DATA_W      = 32;
  localparam int unsigned BE_W        = 4;

  localparam logic [BE_W-1:0] BE_ALL = {BE_W{1'b1}};

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_I    = 2'd1,
    GNT_D    = 2'd2
  } grant_e;

endpackage

// File: rtl/ram_port_arbiter.sv
// Shares one single-port RAM between the instruction-fetch and data ports.
// Data wins collisions unless the fetch side has waited STARVE_LIMIT grants.
module ram_port_arbiter
  import core_mem_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_req,
  input  logic [WORD_ADDR_W-1:0] i_addr,
  output logic                   i_gnt,
  output logic                   i_rvalid,
  output logic [DATA_W-1:0]      i_rdata,
  input  logic                   d_req,
  input  logic                   d_we,
  input  logic [BE_W-1:0]        d_be,
  input  logic [WORD_ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0]      d_wdata,
  output logic                   d_gnt,
  output logic                   d_rvalid,
  output logic [DATA_W-1:0]      d_rdata,
  output logic [WORD_ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0]      ram_di,
  output logic                   ram_we,
  output logic [BE_W-1:0]        ram_be,
  input  logic [DATA_W-1:0]      ram_do
);

  localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 2);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  grant_e           gnt;
  logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
  logic             i_rvalid_q, i_rvalid_d;
  logic             d_rvalid_q, d_rvalid_d;

  // Grant decision: nothing is granted while reset is held.
  always_comb begin
    gnt = GNT_NONE;
    if (!reset) begin
      if (i_req && (!d_req || (starve_cnt_q == LIMIT))) begin
        gnt = GNT_I;
      end else if (d_req) begin
        gnt = GNT_D;
      end
    end
  end

  assign i_gnt = (gnt == GNT_I);
  assign d_gnt = (gnt == GNT_D);

  // RAM request mux; an idle port drives all zeros.
  always_comb begin
    ram_addr = '0;
    ram_di   = '0;
    ram_we   = 1'b0;
    ram_be   = '0;
    unique case (gnt)
      GNT_I: begin
        ram_addr = i_addr;
        ram_be   = BE_ALL;
      end
      GNT_D: begin
        ram_addr = d_addr;
        ram_di   = d_wdata;
        ram_we   = d_we;
        ram_be   = d_be;
      end
      default: ;
    endcase
  end

  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (i_gnt || !i_req) begin
      starve_cnt_d = '0;
    end else if (d_gnt && (starve_cnt_q != LIMIT)) begin
      starve_cnt_d = starve_cnt_q + 1'b1;
    end
  end

  // Stores finish in their grant cycle, so only loads and fetches expect data.
  assign i_rvalid_d = i_gnt;
  assign d_rvalid_d = d_gnt && !d_we;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_cnt_q <= '0;
      i_rvalid_q   <= 1'b0;
      d_rvalid_q   <= 1'b0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      i_rvalid_q   <= i_rvalid_d;
      d_rvalid_q   <= d_rvalid_d;
    end
  end

  assign i_rvalid = i_rvalid_q;
  assign d_rvalid = d_rvalid_q;
  assign i_rdata  = i_rvalid_q ? ram_do : '0;
  assign d_rdata  = d_rvalid_q ? ram_do : '0;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Randomized bench for ram_port_arbiter against a transaction-level model with a shadow memory.
module tb_ram_port_arbiter;

  localparam int LIM = 4;

  logic        clk;
  logic        reset;
  logic        i_req;
  logic [13:0] i_addr;
  logic        i_gnt;
  logic        i_rvalid;
  logic [31:0] i_rdata;
  logic        d_req;
  logic        d_we;
  logic [3:0]  d_be;
  logic [13:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic [13:0] ram_addr;
  logic [31:0] ram_di;
  logic        ram_we;
  logic [3:0]  ram_be;
  logic [31:0] ram_do;

  ram_port_arbiter #(.STARVE_LIMIT(LIM)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .ram_addr(ram_addr), .ram_di(ram_di), .ram_we(ram_we), .ram_be(ram_be), .ram_do(ram_do)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // RAM behind the DUT and the model's independent view of memory contents.
  logic [31:0] mem     [16384];
  logic [31:0] ref_mem [16384];

  int          waits;
  bit          exp_irv, exp_drv;
  logic [31:0] exp_ird, exp_drd;
  logic        obs_ig, obs_dg;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  task automatic step(input bit rst_v, input bit ireq, input logic [13:0] ia,
                      input bit dreq, input bit dwe, input logic [3:0] be,
                      input logic [13:0] da, input logic [31:0] wd);
    bit          eig, edg;
    logic [13:0] ca;
    logic [31:0] cd, rd;
    logic        cw;
    logic [3:0]  cb;
    @(negedge clk);
    reset = rst_v; i_req = ireq; i_addr = ia;
    d_req = dreq; d_we = dwe; d_be = be; d_addr = da; d_wdata = wd;
    #1;
    if (rst_v) begin
      waits = 0; exp_irv = 0; exp_drv = 0;
    end
    check_val("i_rvalid", {31'b0, i_rvalid}, {31'b0, exp_irv});
    check_val("i_rdata", i_rdata, exp_irv ? exp_ird : 32'h0);
    check_val("d_rvalid", {31'b0, d_rvalid}, {31'b0, exp_drv});
    check_val("d_rdata", d_rdata, exp_drv ? exp_drd : 32'h0);

    eig = 0; edg = 0;
    if (!rst_v) begin
      if (ireq && (!dreq || waits == LIM)) eig = 1;
      else if (dreq) edg = 1;
    end
    obs_ig = i_gnt; obs_dg = d_gnt;
    check_val("i_gnt", {31'b0, i_gnt}, {31'b0, eig});
    check_val("d_gnt", {31'b0, d_gnt}, {31'b0, edg});
    check_val("ram_addr", {18'b0, ram_addr}, eig ? {18'b0, ia} : edg ? {18'b0, da} : 32'h0);
    check_val("ram_we", {31'b0, ram_we}, {31'b0, edg && dwe});
    check_val("ram_be", {28'b0, ram_be}, eig ? 32'hF : edg ? {28'b0, be} : 32'h0);
    if (!eig) check_val("ram_di", ram_di, edg ? wd : 32'h0);

    exp_irv = eig; exp_ird = ref_mem[ia];
    exp_drv = edg && !dwe; exp_drd = ref_mem[da];
    if (edg && dwe) ref_mem[da] = merge(ref_mem[da], wd, be);
    if (!rst_v) begin
      if (eig || !ireq) waits = 0;
      else if (edg && waits < LIM) waits++;
    end

    ca = ram_addr; cw = ram_we; cb = ram_be; cd = ram_di;
    @(posedge clk);
    rd = mem[ca];
    if (cw) mem[ca] = merge(mem[ca], cd, cb);
    ram_do = rd;
  endtask

  task automatic idle(input bit rst_v);
    step(rst_v, 0, 14'h0, 0, 0, 4'h0, 14'h0, 32'h0);
  endtask

  initial begin
    reset = 1'b1; i_req = 0; i_addr = '0; d_req = 0; d_we = 0; d_be = '0;
    d_addr = '0; d_wdata = '0; ram_do = '0;
    waits = 0; exp_irv = 0; exp_drv = 0; exp_ird = '0; exp_drd = '0;
    for (int a = 0; a < 16384; a++) begin
      logic [31:0] v;
      v = $urandom;
      mem[a] = v; ref_mem[a] = v;
    end
    mem[14'h0010] = 32'h0000_0013; ref_mem[14'h0010] = 32'h0000_0013;

    // Reset held with both requesters active: nothing may be granted.
    step(1, 1, 14'h1, 1, 1, 4'hF, 14'h2, 32'h1234_5678);
    check_val("rst_i_gnt", {31'b0, obs_ig}, 32'h0);
    check_val("rst_d_gnt", {31'b0, obs_dg}, 32'h0);
    check_val("rst_ram_be", {28'b0, ram_be}, 32'h0);
    idle(1);

    // Lone fetch of word 0x10.
    step(0, 1, 14'h0010, 0, 0, 4'h0, 14'h0, 32'h0);
    check_val("fetch_gnt", {31'b0, obs_ig}, 32'h1);
    idle(0);
    check_val("fetch_rvalid", {31'b0, i_rvalid}, 32'h1);
    check_val("fetch_rdata", i_rdata, 32'h0000_0013);

    // Collision: the load wins.
    step(0, 1, 14'h0010, 1, 0, 4'h0, 14'h0200, 32'h0);
    check_val("coll_d_gnt", {31'b0, obs_dg}, 32'h1);
    check_val("coll_i_gnt", {31'b0, obs_ig}, 32'h0);
    idle(0);
    check_val("coll_rvalid", {31'b0, d_rvalid}, 32'h1);

    // Starvation: four data grants, then the fetch, then data again.
    for (int k = 0; k < 6; k++) begin
      step(0, 1, 14'h0020, 1, 0, 4'h0, 14'h0030, 32'h0);
      check_val($sformatf("starve_i%0d", k), {31'b0, obs_ig}, {31'b0, k == 4});
      check_val($sformatf("starve_d%0d", k), {31'b0, obs_dg}, {31'b0, k != 4});
    end
    idle(0);

    // Byte-enabled store, then read it back.
    step(0, 0, 14'h0, 1, 1, 4'b0011, 14'h0040, 32'hAABB_CCDD);
    check_val("store_we", {31'b0, ram_we}, 32'h1);
    idle(0);
    check_val("store_no_rvalid", {31'b0, d_rvalid}, 32'h0);
    step(0, 0, 14'h0, 1, 0, 4'h0, 14'h0040, 32'h0);
    idle(0);
    check_val("store_readback_lo", {16'b0, d_rdata[15:0]}, 32'h0000_CCDD);

    // Reset arriving in the cycle after a load grant drops the response.
    step(0, 0, 14'h0, 1, 0, 4'h0, 14'h0200, 32'h0);
    idle(1);
    check_val("midrd_rvalid", {31'b0, d_rvalid}, 32'h0);
    idle(1);
    step(0, 1, 14'h0005, 0, 0, 4'h0, 14'h0, 32'h0);
    check_val("post_rst_rvalid", {31'b0, d_rvalid}, 32'h0);
    check_val("post_rst_gnt", {31'b0, obs_ig}, 32'h1);

    // Idle port.
    idle(0);
    idle(0);
    check_val("idle_rvalid", {30'b0, i_rvalid, d_rvalid}, 32'h0);

    // Randomized traffic over a small address window to force hazards.
    for (int n = 0; n < 3000; n++) begin
      step($urandom_range(0, 49) == 0,
           $urandom_range(0, 3) != 0, 14'($urandom_range(0, 15)),
           $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
           4'($urandom), 14'($urandom_range(0, 15)), $urandom);
    end
    idle(0);
    idle(0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
